// File: rtl/dmem_responder.sv
// Byte-addressed little-endian data memory behind a valid/ready request channel
// with a programmable number of wait states before a single-cycle response pulse.
module dmem_responder #(
    parameter int ADDR_WIDTH  = 8,
    parameter int WAIT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_error
);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    localparam int         DEPTH = 2 ** ADDR_WIDTH;
    localparam logic [3:0] LAST  = 4'(WAIT_CYCLES - 1);

    logic [7:0] bytes [DEPTH];

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        write_q, write_d;
    logic [1:0]  size_q, size_d;
    logic        signed_q, signed_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rdata_q, rdata_d;
    logic        error_q, error_d;

    logic                  go_resp;
    logic                  acc_write, acc_signed, acc_err;
    logic [1:0]            acc_size;
    logic [31:0]           acc_addr, acc_wdata, ld_data;
    logic [ADDR_WIDTH-1:0] idx;
    logic [7:0]            b0, b1, b2, b3;
    logic                  mem_we;

    // With zero wait states the access resolves on the acceptance edge itself,
    // so it must use the live request rather than the latched copy.
    always_comb begin
        if (state_q == IDLE) begin
            acc_write  = req_write;
            acc_size   = req_size;
            acc_signed = req_signed;
            acc_addr   = req_addr;
            acc_wdata  = req_wdata;
        end else begin
            acc_write  = write_q;
            acc_size   = size_q;
            acc_signed = signed_q;
            acc_addr   = addr_q;
            acc_wdata  = wdata_q;
        end
    end

    always_comb begin
        idx     = acc_addr[ADDR_WIDTH-1:0];
        acc_err = (acc_size == 2'b11)
               || (acc_size == 2'b01 && acc_addr[0])
               || (acc_size == 2'b10 && acc_addr[1:0] != 2'b00)
               || ((acc_addr >> ADDR_WIDTH) != 32'd0);
        b0 = bytes[idx];
        b1 = bytes[idx + ADDR_WIDTH'(1)];
        b2 = bytes[idx + ADDR_WIDTH'(2)];
        b3 = bytes[idx + ADDR_WIDTH'(3)];
        case (acc_size)
            2'b00:   ld_data = {{24{acc_signed & b0[7]}}, b0};
            2'b01:   ld_data = {{16{acc_signed & b1[7]}}, b1, b0};
            default: ld_data = {b3, b2, b1, b0};
        endcase
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        write_d  = write_q;
        size_d   = size_q;
        signed_d = signed_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        rdata_d  = rdata_q;
        error_d  = error_q;
        go_resp  = 1'b0;
        case (state_q)
            IDLE: if (req_valid) begin
                write_d  = req_write;
                size_d   = req_size;
                signed_d = req_signed;
                addr_d   = req_addr;
                wdata_d  = req_wdata;
                cnt_d    = 4'd0;
                if (WAIT_CYCLES == 0) begin
                    state_d = RESP;
                    go_resp = 1'b1;
                end else begin
                    state_d = WAIT;
                end
            end
            WAIT: if (cnt_q == LAST) begin
                state_d = RESP;
                go_resp = 1'b1;
                cnt_d   = 4'd0;
            end else begin
                cnt_d = cnt_q + 4'd1;
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (go_resp) begin
            error_d = acc_err;
            rdata_d = (acc_err || acc_write) ? 32'd0 : ld_data;
        end
    end

    // Stores land only on the edge entering RESP; reset before then drops them.
    assign mem_we = go_resp && acc_write && !acc_err && reset_n;

    always_ff @(posedge clk) begin
        if (mem_we) begin
            bytes[idx] <= acc_wdata[7:0];
            if (acc_size != 2'b00)
                bytes[idx + ADDR_WIDTH'(1)] <= acc_wdata[15:8];
            if (acc_size == 2'b10) begin
                bytes[idx + ADDR_WIDTH'(2)] <= acc_wdata[23:16];
                bytes[idx + ADDR_WIDTH'(3)] <= acc_wdata[31:24];
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            cnt_q    <= 4'd0;
            write_q  <= 1'b0;
            size_q   <= 2'b00;
            signed_q <= 1'b0;
            addr_q   <= 32'd0;
            wdata_q  <= 32'd0;
            rdata_q  <= 32'd0;
            error_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            write_q  <= write_d;
            size_q   <= size_d;
            signed_q <= signed_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            rdata_q  <= rdata_d;
            error_q  <= error_d;
        end
    end

    assign req_ready  = (state_q == IDLE);
    assign resp_valid = (state_q == RESP);
    assign resp_rdata = rdata_q;
    assign resp_error = error_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Drives three responders (0, 1 and 3 wait states) with directed and random
// traffic, checking every cycle against a byte-array reference model.
module tb_dmem_responder;

    localparam int NI = 3;
    localparam int AW = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                 reset_n;
    logic [NI-1:0]        req_valid, req_write, req_signed, req_ready, resp_valid, resp_error;
    logic [NI-1:0][1:0]   req_size;
    logic [NI-1:0][31:0]  req_addr, req_wdata, resp_rdata;

    dmem_responder #(.ADDR_WIDTH(AW), .WAIT_CYCLES(0)) u0 (
        .clk(clk), .reset_n(reset_n), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
        .req_write(req_write[0]), .req_size(req_size[0]), .req_signed(req_signed[0]),
        .req_addr(req_addr[0]), .req_wdata(req_wdata[0]), .resp_valid(resp_valid[0]),
        .resp_rdata(resp_rdata[0]), .resp_error(resp_error[0]));
    dmem_responder #(.ADDR_WIDTH(AW), .WAIT_CYCLES(1)) u1 (
        .clk(clk), .reset_n(reset_n), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
        .req_write(req_write[1]), .req_size(req_size[1]), .req_signed(req_signed[1]),
        .req_addr(req_addr[1]), .req_wdata(req_wdata[1]), .resp_valid(resp_valid[1]),
        .resp_rdata(resp_rdata[1]), .resp_error(resp_error[1]));
    dmem_responder #(.ADDR_WIDTH(AW), .WAIT_CYCLES(3)) u3 (
        .clk(clk), .reset_n(reset_n), .req_valid(req_valid[2]), .req_ready(req_ready[2]),
        .req_write(req_write[2]), .req_size(req_size[2]), .req_signed(req_signed[2]),
        .req_addr(req_addr[2]), .req_wdata(req_wdata[2]), .resp_valid(resp_valid[2]),
        .resp_rdata(resp_rdata[2]), .resp_error(resp_error[2]));

    // Reference model: byte array per instance plus at most one outstanding access.
    logic [7:0]  mem_m [NI][256];
    bit          pend [NI];
    int          acc_c [NI], due_c [NI];
    logic [31:0] exp_rd [NI];
    bit          exp_er [NI];
    bit          pw [NI];
    logic [31:0] pa [NI], pd [NI];
    int          pn [NI];
    int          cyc = 0;
    int          total = 0, bad = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic int wt(input int k);
        return (k == 0) ? 0 : (k == 1) ? 1 : 3;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic void model_accept(input int k, input bit w, input logic [1:0] sz,
                                         input bit sg, input logic [31:0] a,
                                         input logic [31:0] d, input int c);
        int nb = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
        bit e = (sz == 2'd3) || (sz == 2'd1 && a % 2 != 0) || (sz == 2'd2 && a % 4 != 0)
                || (a >= 32'(1 << AW));
        logic [31:0] r = 32'd0;
        if (!e && !w) begin
            for (int i = 0; i < nb; i++) r = r | (32'(mem_m[k][int'(a) + i]) << (8 * i));
            if (sg && nb < 4 && r[8*nb-1]) r = r | (32'hFFFF_FFFF << (8 * nb));
        end
        pend[k]   = 1'b1;
        acc_c[k]  = c;
        due_c[k]  = c + wt(k) + 1;
        exp_rd[k] = r;
        exp_er[k] = e;
        pw[k]     = w && !e;
        pa[k]     = a;
        pd[k]     = d;
        pn[k]     = nb;
    endfunction

    function automatic void model_commit(input int k);
        for (int i = 0; i < pn[k]; i++) mem_m[k][int'(pa[k]) + i] = 8'(pd[k] >> (8 * i));
    endfunction

    always @(negedge clk) begin
        bit ev, er;
        for (int k = 0; k < NI; k++) begin
            if (!reset_n) begin
                chk($sformatf("rst_ready[%0d]", k), 32'(req_ready[k]), 32'd1);
                chk($sformatf("rst_valid[%0d]", k), 32'(resp_valid[k]), 32'd0);
                chk($sformatf("rst_rdata[%0d]", k), resp_rdata[k], 32'd0);
                chk($sformatf("rst_error[%0d]", k), 32'(resp_error[k]), 32'd0);
            end else begin
                ev = pend[k] && cyc == due_c[k];
                er = !(pend[k] && cyc > acc_c[k] && cyc <= due_c[k]);
                chk($sformatf("ready[%0d]", k), 32'(req_ready[k]), 32'(er));
                chk($sformatf("valid[%0d]", k), 32'(resp_valid[k]), 32'(ev));
                if (ev) begin
                    chk($sformatf("rdata[%0d]", k), resp_rdata[k], exp_rd[k]);
                    chk($sformatf("error[%0d]", k), 32'(resp_error[k]), 32'(exp_er[k]));
                    if (pw[k]) model_commit(k);
                    pend[k] = 1'b0;
                end
            end
        end
    end

    task automatic do_req(input int k, input bit w, input logic [1:0] sz, input bit sg,
                          input logic [31:0] a, input logic [31:0] d, input bit keep,
                          output int acc);
        req_write[k]  = w;
        req_size[k]   = sz;
        req_signed[k] = sg;
        req_addr[k]   = a;
        req_wdata[k]  = d;
        req_valid[k]  = 1'b1;
        acc = -1;
        for (int n = 0; n < 40; n++) begin
            if (req_ready[k]) begin
                acc = cyc;
                model_accept(k, w, sz, sg, a, d, cyc);
                @(posedge clk);
                @(negedge clk);
                break;
            end
            @(posedge clk);
            @(negedge clk);
        end
        if (acc < 0) chk("accept_timeout", 32'd0, 32'd1);
        if (!keep) req_valid[k] = 1'b0;
    endtask

    task automatic wait_resp(input int k, input int acc, output logic [31:0] rd,
                             output logic er, output int lat);
        rd = 32'hx; er = 1'bx; lat = -1;
        for (int n = 0; n < 30; n++) begin
            if (resp_valid[k]) begin
                rd = resp_rdata[k]; er = resp_error[k]; lat = cyc - acc;
                break;
            end
            @(negedge clk);
        end
        if (lat < 0) chk("resp_timeout", 32'd0, 32'd1);
    endtask

    task automatic check_mem();
        int nm0 = 0, nm1 = 0, nm3 = 0;
        for (int i = 0; i < 256; i++) begin
            if (u0.bytes[i] !== mem_m[0][i]) nm0++;
            if (u1.bytes[i] !== mem_m[1][i]) nm1++;
            if (u3.bytes[i] !== mem_m[2][i]) nm3++;
        end
        chk("mem_u0", 32'(nm0), 32'd0);
        chk("mem_u1", 32'(nm1), 32'd0);
        chk("mem_u3", 32'(nm3), 32'd0);
    endtask

    initial begin
        int          acc, acc2, lat;
        logic [31:0] rd, snap;
        logic        er;
        reset_n    = 1'b0;
        req_valid  = '0;
        req_write  = '0;
        req_signed = '0;
        req_size   = '0;
        req_addr   = '0;
        req_wdata  = '0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);

        for (int k = 0; k < NI; k++)
            for (int a = 0; a < 256; a += 4) do_req(k, 1'b1, 2'd2, 1'b0, 32'(a), $urandom, 1'b0, acc);
        repeat (6) @(negedge clk);

        // Hand-computed expectations on the one-wait-state instance.
        do_req(1, 1'b1, 2'd2, 1'b0, 32'd12, 32'd4, 1'b0, acc);
        wait_resp(1, acc, rd, er, lat);
        chk("st12_lat", 32'(lat), 32'd2);
        chk("st12_err", 32'(er), 32'd0);
        chk("st12_bytes", {u1.bytes[15], u1.bytes[14], u1.bytes[13], u1.bytes[12]}, 32'h0000_0004);
        do_req(1, 1'b0, 2'd2, 1'b0, 32'd12, 32'd0, 1'b0, acc);
        wait_resp(1, acc, rd, er, lat);
        chk("ld12", rd, 32'd4);
        do_req(1, 1'b1, 2'd2, 1'b0, 32'd12, 32'hFF00_0000, 1'b0, acc);
        do_req(1, 1'b0, 2'd0, 1'b1, 32'd15, 32'd0, 1'b0, acc);
        wait_resp(1, acc, rd, er, lat);
        chk("ldb15_s", rd, 32'hFFFF_FFFF);
        do_req(1, 1'b0, 2'd0, 1'b0, 32'd15, 32'd0, 1'b0, acc);
        wait_resp(1, acc, rd, er, lat);
        chk("ldb15_u", rd, 32'h0000_00FF);
        do_req(1, 1'b1, 2'd0, 1'b0, 32'd0, 32'h11, 1'b0, acc);
        do_req(1, 1'b1, 2'd0, 1'b0, 32'd1, 32'h22, 1'b0, acc);
        do_req(1, 1'b1, 2'd1, 1'b0, 32'd2, 32'hBEEF, 1'b0, acc);
        do_req(1, 1'b0, 2'd2, 1'b0, 32'd0, 32'd0, 1'b0, acc);
        wait_resp(1, acc, rd, er, lat);
        chk("ld0_word", rd, 32'hBEEF_2211);
        snap = {u1.bytes[16], u1.bytes[15], u1.bytes[14], u1.bytes[13]};
        do_req(1, 1'b1, 2'd2, 1'b0, 32'd13, 32'hCAFE_F00D, 1'b0, acc);
        wait_resp(1, acc, rd, er, lat);
        chk("mis13_err", 32'(er), 32'd1);
        chk("mis13_rd", rd, 32'd0);
        chk("mis13_bytes", {u1.bytes[16], u1.bytes[15], u1.bytes[14], u1.bytes[13]}, snap);
        do_req(1, 1'b0, 2'd1, 1'b1, 32'd1, 32'd0, 1'b0, acc);
        wait_resp(1, acc, rd, er, lat);
        chk("mish1_err", 32'(er), 32'd1);
        chk("mish1_rd", rd, 32'd0);
        do_req(1, 1'b0, 2'd2, 1'b0, 32'h100, 32'd0, 1'b0, acc);
        wait_resp(1, acc, rd, er, lat);
        chk("oor_err", 32'(er), 32'd1);

        // Zero-wait instance with request valid held across two accesses.
        do_req(0, 1'b1, 2'd2, 1'b0, 32'd40, 32'h1234_5678, 1'b1, acc);
        chk("b2b_v1", 32'(resp_valid[0]), 32'd1);
        chk("b2b_rdy1", 32'(req_ready[0]), 32'd0);
        do_req(0, 1'b0, 2'd2, 1'b0, 32'd40, 32'd0, 1'b0, acc2);
        chk("b2b_gap", 32'(acc2 - acc), 32'd2);
        wait_resp(0, acc2, rd, er, lat);
        chk("b2b_lat", 32'(lat), 32'd1);
        chk("b2b_rd", rd, 32'h1234_5678);

        // Reset in the middle of a three-wait-state store.
        snap = {u3.bytes[23], u3.bytes[22], u3.bytes[21], u3.bytes[20]};
        do_req(2, 1'b1, 2'd2, 1'b0, 32'd20, 32'hDEAD_BEEF, 1'b0, acc);
        @(negedge clk);
        #2;
        reset_n = 1'b0;
        for (int k = 0; k < NI; k++) pend[k] = 1'b0;
        #1;
        chk("abort_ready", 32'(req_ready[2]), 32'd1);
        chk("abort_valid", 32'(resp_valid[2]), 32'd0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        repeat (6) @(negedge clk);
        chk("abort_bytes", {u3.bytes[23], u3.bytes[22], u3.bytes[21], u3.bytes[20]}, snap);

        for (int n = 0; n < 300; n++) begin
            int          k, r;
            logic [1:0]  sz;
            logic [31:0] a;
            k  = $urandom_range(0, NI - 1);
            r  = $urandom_range(0, 9);
            sz = (r < 3) ? 2'd0 : (r < 6) ? 2'd1 : (r < 9) ? 2'd2 : 2'd3;
            a  = ($urandom_range(0, 15) == 0) ? 32'($urandom_range(256, 300)) : 32'($urandom_range(0, 255));
            if ($urandom_range(0, 3) != 0) begin
                if (sz == 2'd1) a[0] = 1'b0;
                if (sz == 2'd2) a[1:0] = 2'b00;
            end
            do_req(k, 1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), a, $urandom, 1'b0, acc);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        repeat (10) @(negedge clk);
        check_mem();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
